// File: rtl/writeback_unit_pkg.sv
// Shared core definitions for the writeback stage: load-op encodings, FSM
// state encoding and the register-file write record.
package writeback_unit_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } ldop_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wr_t;

  // GPR 0 is hardwired to zero, so any write aimed at it is suppressed.
  function automatic wr_t mask_r0(input wr_t w);
    wr_t r;
    r = w;
    if (w.waddr == 5'd0) begin
      r.we = 4'b0000;
    end
    return r;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// MEM-stage, data-bus response and register-file write signals of the
// writeback stage; slave is the writeback unit, master is its environment.
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  logic        mem_valid;
  logic [3:0]  mem_wreg;
  logic [4:0]  mem_wraddr;
  logic [31:0] mem_alures;
  ldop_e       mem_ldop;
  logic [1:0]  mem_addrlo;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        wb_flush;
  logic        wb_stall;
  logic [3:0]  we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport slave (
    input  mem_valid, mem_wreg, mem_wraddr, mem_alures, mem_ldop, mem_addrlo,
    input  dbus_rvalid, dbus_rdata, wb_flush,
    output wb_stall, we, waddr, wdata
  );

  modport master (
    output mem_valid, mem_wreg, mem_wraddr, mem_alures, mem_ldop, mem_addrlo,
    output dbus_rvalid, dbus_rdata, wb_flush,
    input  wb_stall, we, waddr, wdata
  );

endinterface

// File: rtl/writeback_unit_load_align.sv
// Combinational load alignment: selects, shifts and extends the bus word for
// the given load type and address, and produces the matching byte enables.
module load_align
  import writeback_unit_pkg::*;
(
  input  ldop_e       ldop_i,
  input  logic [1:0]  addrlo_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [1:0]  lwl_shift;

  always_comb begin
    byte_sel  = rdata_i[{addrlo_i, 3'b000} +: 8];
    half_sel  = addrlo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    lwl_shift = 2'd3 - addrlo_i;
    we_o      = 4'b0000;
    wdata_o   = 32'h0;
    case (ldop_i)
      LD_LB: begin
        we_o    = 4'b1111;
        wdata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      LD_LBU: begin
        we_o    = 4'b1111;
        wdata_o = {24'h0, byte_sel};
      end
      LD_LH: begin
        we_o    = 4'b1111;
        wdata_o = {{16{half_sel[15]}}, half_sel};
      end
      LD_LHU: begin
        we_o    = 4'b1111;
        wdata_o = {16'h0, half_sel};
      end
      LD_LW: begin
        we_o    = 4'b1111;
        wdata_o = rdata_i;
      end
      // Unaligned pairs: LWL fills the top bytes, LWR the bottom bytes; the
      // shifts leave the untouched bytes zero.
      LD_LWL: begin
        we_o    = 4'b1111 << lwl_shift;
        wdata_o = rdata_i << {lwl_shift, 3'b000};
      end
      LD_LWR: begin
        we_o    = 4'b1111 >> addrlo_i;
        wdata_o = rdata_i >> {addrlo_i, 3'b000};
      end
      default: begin
        we_o    = 4'b0000;
        wdata_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: registers ALU results or aligned load data into the
// register-file write port, stalling MEM while a load response is outstanding.
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  writeback_unit_if.slave  wb
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  ld_waddr_q, ld_waddr_d;
  ldop_e       ld_op_q, ld_op_d;
  logic [1:0]  ld_addrlo_q, ld_addrlo_d;
  wr_t         out_q, out_d;
  wr_t         pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;

  logic        stall;
  logic        accept;
  logic        is_load;
  logic        complete;
  logic [3:0]  align_we;
  logic [31:0] align_wdata;
  wr_t         mem_wr;
  wr_t         sel_wr;

  load_align u_align (
    .ldop_i   (ld_op_q),
    .addrlo_i (ld_addrlo_q),
    .rdata_i  (wb.dbus_rdata),
    .we_o     (align_we),
    .wdata_o  (align_wdata)
  );

  always_comb begin
    stall    = ((state_q == ST_WAIT) && !wb.dbus_rvalid) || (state_q == ST_DRAIN);
    accept   = wb.mem_valid && !stall && !wb.wb_flush;
    is_load  = (wb.mem_ldop != LD_NONE);
    complete = (state_q == ST_WAIT) && wb.dbus_rvalid && !wb.wb_flush;
    mem_wr.we    = wb.mem_wreg;
    mem_wr.waddr = wb.mem_wraddr;
    mem_wr.wdata = wb.mem_alures;
  end

  // A non-load accepted in the cycle a load completes cannot share the single
  // write port, so it waits one cycle in pend_q; it stays there only while
  // back-to-back non-loads keep arriving, and a load always lets it drain.
  always_comb begin
    sel_wr      = out_q;
    sel_wr.we   = 4'b0000;
    pend_d      = pend_q;
    pend_vld_d  = 1'b0;
    if (complete) begin
      sel_wr.we    = align_we;
      sel_wr.waddr = ld_waddr_q;
      sel_wr.wdata = align_wdata;
    end else if (pend_vld_q) begin
      sel_wr = pend_q;
    end else if (accept && !is_load) begin
      sel_wr = mem_wr;
    end
    if (accept && !is_load && (complete || pend_vld_q)) begin
      pend_d     = mem_wr;
      pend_vld_d = 1'b1;
    end
    out_d = mask_r0(sel_wr);
  end

  always_comb begin
    state_d     = state_q;
    ld_waddr_d  = ld_waddr_q;
    ld_op_d     = ld_op_q;
    ld_addrlo_d = ld_addrlo_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: begin
        if (wb.dbus_rvalid) begin
          state_d = ST_IDLE;
        end else if (wb.wb_flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wb.dbus_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept && is_load) begin
      state_d     = ST_WAIT;
      ld_waddr_d  = wb.mem_wraddr;
      ld_op_d     = wb.mem_ldop;
      ld_addrlo_d = wb.mem_addrlo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ld_waddr_q  <= 5'd0;
      ld_op_q     <= LD_NONE;
      ld_addrlo_q <= 2'd0;
      out_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_waddr_q  <= ld_waddr_d;
      ld_op_q     <= ld_op_d;
      ld_addrlo_q <= ld_addrlo_d;
      out_q       <= out_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
    end
  end

  // Reset is asynchronous, so the combinational stall must also drop at once.
  assign wb.wb_stall = stall && !rst;
  assign wb.we       = out_q.we;
  assign wb.waddr    = out_q.waddr;
  assign wb.wdata    = out_q.wdata;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed table-driven bench for writeback_unit plus hand sequences for
// flush, drain, back-to-back loads, r0 and mid-load reset.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  typedef struct {
    ldop_e       op;
    logic [3:0]  wreg;
    logic [4:0]  rd;
    logic [31:0] alures;
    logic [1:0]  lo;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  vec_t vecs[NVEC];

  writeback_unit_if bus();

  writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_valid   = 1'b0;
    bus.mem_wreg    = 4'b0000;
    bus.mem_wraddr  = 5'd0;
    bus.mem_alures  = 32'h0;
    bus.mem_ldop    = LD_NONE;
    bus.mem_addrlo  = 2'd0;
    bus.dbus_rvalid = 1'b0;
    bus.dbus_rdata  = 32'h0;
    bus.wb_flush    = 1'b0;
  endtask

  task automatic issue(input ldop_e op, input logic [3:0] wreg, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [1:0] lo);
    bus.mem_valid  = 1'b1;
    bus.mem_ldop   = op;
    bus.mem_wreg   = wreg;
    bus.mem_wraddr = rd;
    bus.mem_alures = alu;
    bus.mem_addrlo = lo;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    issue(v.op, v.wreg, v.rd, v.alures, v.lo);
    #1 chk($sformatf("v%0d_accept_stall", idx), {31'h0, bus.wb_stall}, 32'h0);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    if (v.op != LD_NONE) begin
      #1 chk($sformatf("v%0d_wait_we", idx), {28'h0, bus.we}, 32'h0);
      for (int i = 0; i < v.lat; i++) begin
        chk($sformatf("v%0d_stall_c%0d", idx, i), {31'h0, bus.wb_stall}, 32'h1);
        @(negedge clk);
      end
      bus.dbus_rvalid = 1'b1;
      bus.dbus_rdata  = v.rdata;
      #1 chk($sformatf("v%0d_resp_stall", idx), {31'h0, bus.wb_stall}, 32'h0);
      @(negedge clk);
      bus.dbus_rvalid = 1'b0;
    end
    #1;
    chk($sformatf("v%0d_we", idx), {28'h0, bus.we}, {28'h0, v.exp_we});
    chk($sformatf("v%0d_waddr", idx), {27'h0, bus.waddr}, {27'h0, v.rd});
    chk($sformatf("v%0d_wdata", idx), bus.wdata, v.exp_wdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    //           op       wreg rd     alures        lo     rdata         lat we       wdata
    vecs[0]  = '{LD_NONE, 4'hF, 5'd5,  32'h1234_5678, 2'd0, 32'h0,         0, 4'b1111, 32'h1234_5678};
    vecs[1]  = '{LD_LB,   4'h0, 5'd7,  32'h0,         2'd3, 32'h80FF_FFFF, 3, 4'b1111, 32'hFFFF_FF80};
    vecs[2]  = '{LD_LWL,  4'h0, 5'd8,  32'h0,         2'd1, 32'hAABB_CCDD, 1, 4'b1100, 32'hCCDD_0000};
    vecs[3]  = '{LD_LWR,  4'h0, 5'd9,  32'h0,         2'd2, 32'hAABB_CCDD, 0, 4'b0011, 32'h0000_AABB};
    vecs[4]  = '{LD_LBU,  4'h0, 5'd10, 32'h0,         2'd1, 32'h1234_8678, 2, 4'b1111, 32'h0000_0086};
    vecs[5]  = '{LD_LH,   4'h0, 5'd11, 32'h0,         2'd3, 32'h8001_1234, 1, 4'b1111, 32'hFFFF_8001};
    vecs[6]  = '{LD_LHU,  4'h0, 5'd12, 32'h0,         2'd0, 32'h1234_F00D, 0, 4'b1111, 32'h0000_F00D};
    vecs[7]  = '{LD_LW,   4'h0, 5'd13, 32'h0,         2'd0, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF};
    vecs[8]  = '{LD_LWL,  4'h0, 5'd14, 32'h0,         2'd0, 32'h1122_3344, 0, 4'b1000, 32'h4400_0000};
    vecs[9]  = '{LD_LWL,  4'h0, 5'd15, 32'h0,         2'd3, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344};
    vecs[10] = '{LD_LWR,  4'h0, 5'd16, 32'h0,         2'd3, 32'h1122_3344, 0, 4'b0001, 32'h0000_0011};
    vecs[11] = '{LD_LWR,  4'h0, 5'd17, 32'h0,         2'd0, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344};
    vecs[12] = '{LD_LWR,  4'h0, 5'd18, 32'h0,         2'd1, 32'h1122_3344, 0, 4'b0111, 32'h0011_2233};
    vecs[13] = '{LD_LB,   4'h0, 5'd19, 32'h0,         2'd0, 32'h0000_007F, 0, 4'b1111, 32'h0000_007F};
    vecs[14] = '{LD_NONE, 4'h3, 5'd3,  32'hCAFE_BABE, 2'd0, 32'h0,         0, 4'b0011, 32'hCAFE_BABE};
    vecs[15] = '{LD_LWL,  4'h0, 5'd1,  32'h0,         2'd2, 32'h1122_3344, 2, 4'b1110, 32'h2233_4400};

    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    chk("rst_we", {28'h0, bus.we}, 32'h0);
    chk("rst_waddr", {27'h0, bus.waddr}, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_stall", {31'h0, bus.wb_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // Flush in WAIT, response two cycles later is drained; next load is clean.
    @(negedge clk);
    issue(LD_LW, 4'h0, 5'd20, 32'h0, 2'd0);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.wb_flush  = 1'b1;
    #1 chk("fl_wait_stall", {31'h0, bus.wb_stall}, 32'h1);
    @(negedge clk);
    bus.wb_flush = 1'b0;
    #1 chk("fl_drain_stall0", {31'h0, bus.wb_stall}, 32'h1);
    chk("fl_drain_we", {28'h0, bus.we}, 32'h0);
    @(negedge clk);
    #1 chk("fl_drain_stall1", {31'h0, bus.wb_stall}, 32'h1);
    @(negedge clk);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h0BAD_0BAD;
    #1 chk("fl_drain_stall_rv", {31'h0, bus.wb_stall}, 32'h1);
    @(negedge clk);
    bus.dbus_rvalid = 1'b0;
    #1 chk("fl_after_we", {28'h0, bus.we}, 32'h0);
    chk("fl_after_stall", {31'h0, bus.wb_stall}, 32'h0);
    @(negedge clk);
    issue(LD_LW, 4'h0, 5'd21, 32'h0, 2'd0);
    @(negedge clk);
    bus.mem_valid   = 1'b0;
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h600D_600D;
    @(negedge clk);
    bus.dbus_rvalid = 1'b0;
    #1 chk("fl_next_we", {28'h0, bus.we}, 32'hF);
    chk("fl_next_waddr", {27'h0, bus.waddr}, 32'd21);
    chk("fl_next_wdata", bus.wdata, 32'h600D_600D);

    // Flush together with the response in WAIT: discarded, outputs hold.
    @(negedge clk);
    issue(LD_LW, 4'h0, 5'd26, 32'h0, 2'd0);
    @(negedge clk);
    bus.mem_valid   = 1'b0;
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h0000_0001;
    bus.wb_flush    = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1 chk("flrv_we", {28'h0, bus.we}, 32'h0);
    chk("flrv_stall", {31'h0, bus.wb_stall}, 32'h0);
    chk("flrv_wdata_hold", bus.wdata, 32'h600D_600D);

    // Flush in IDLE blocks the accept.
    @(negedge clk);
    issue(LD_NONE, 4'hF, 5'd6, 32'h7777_7777, 2'd0);
    bus.wb_flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1 chk("fli_we", {28'h0, bus.we}, 32'h0);
    chk("fli_waddr_hold", {27'h0, bus.waddr}, 32'd21);

    // Stray response in IDLE is ignored.
    @(negedge clk);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h5555_5555;
    @(negedge clk);
    bus.dbus_rvalid = 1'b0;
    #1 chk("idle_rv_we", {28'h0, bus.we}, 32'h0);
    chk("idle_rv_stall", {31'h0, bus.wb_stall}, 32'h0);

    // Back-to-back loads: a new load is accepted in the completing cycle.
    @(negedge clk);
    issue(LD_LW, 4'h0, 5'd22, 32'h0, 2'd0);
    @(negedge clk);
    issue(LD_LB, 4'h0, 5'd24, 32'h0, 2'd2);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h0000_0011;
    #1 chk("b2b_stall", {31'h0, bus.wb_stall}, 32'h0);
    @(negedge clk);
    bus.mem_valid   = 1'b0;
    bus.dbus_rvalid = 1'b0;
    #1 chk("b2b_1_we", {28'h0, bus.we}, 32'hF);
    chk("b2b_1_waddr", {27'h0, bus.waddr}, 32'd22);
    chk("b2b_1_wdata", bus.wdata, 32'h0000_0011);
    chk("b2b_2_stall", {31'h0, bus.wb_stall}, 32'h1);
    @(negedge clk);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h00AB_0000;
    @(negedge clk);
    bus.dbus_rvalid = 1'b0;
    #1 chk("b2b_2_we", {28'h0, bus.we}, 32'hF);
    chk("b2b_2_waddr", {27'h0, bus.waddr}, 32'd24);
    chk("b2b_2_wdata", bus.wdata, 32'hFFFF_FFAB);

    // LW to r0 never writes.
    @(negedge clk);
    issue(LD_LW, 4'h0, 5'd0, 32'h0, 2'd0);
    @(negedge clk);
    bus.mem_valid   = 1'b0;
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h1234_5678;
    @(negedge clk);
    bus.dbus_rvalid = 1'b0;
    #1 chk("r0_we", {28'h0, bus.we}, 32'h0);

    // Reset in WAIT: outputs clear at once, the late response is ignored.
    @(negedge clk);
    issue(LD_LW, 4'h0, 5'd25, 32'h0, 2'd0);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rstw_we", {28'h0, bus.we}, 32'h0);
    chk("rstw_waddr", {27'h0, bus.waddr}, 32'h0);
    chk("rstw_wdata", bus.wdata, 32'h0);
    chk("rstw_stall", {31'h0, bus.wb_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'hFFFF_FFFF;
    #1 chk("rstw_late_stall", {31'h0, bus.wb_stall}, 32'h0);
    @(negedge clk);
    bus.dbus_rvalid = 1'b0;
    #1 chk("rstw_late_we", {28'h0, bus.we}, 32'h0);
    chk("rstw_late_wdata", bus.wdata, 32'h0);
    chk("rstw_late_waddr", {27'h0, bus.waddr}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
